// File: rtl/fp32_pkg.sv
// Shared fp32 constants, FSM state encoding and helpers for the squarer and
// sum-of-squares stages.
package fp32_pkg;

  localparam int unsigned FP_EXP_W   = 8;
  localparam int unsigned FP_MANT_W  = 23;
  localparam int unsigned FP_BIAS    = 127;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_EMIT  = 3'd4
  } state_e;

  // Both inf and NaN carry the all-ones exponent.
  function automatic logic is_inf_nan(input logic [31:0] v);
    return v[30:23] == FP_EXP_MAX;
  endfunction

endpackage

// File: rtl/fp32_align.sv
// Operand alignment for magnitude-only fp32 addition: exponent compare, swap so
// the larger exponent comes first, right shift of the smaller mantissa.
module fp32_align
  import fp32_pkg::*;
(
  input  logic [30:0] a_i,
  input  logic [30:0] b_i,
  output logic [7:0]  exp_o,
  output logic [23:0] mant_big_o,
  output logic [23:0] mant_small_o
);

  logic [7:0]  exp_a, exp_b, exp_s, shamt;
  logic [23:0] mant_a, mant_b, mant_s;
  logic        swap;

  always_comb begin
    exp_a = a_i[30:23];
    exp_b = b_i[30:23];
    // Zero exponent means zero: denormals are flushed, no hidden bit.
    mant_a = (exp_a == 8'd0) ? 24'd0 : {1'b1, a_i[22:0]};
    mant_b = (exp_b == 8'd0) ? 24'd0 : {1'b1, b_i[22:0]};
    swap   = exp_b > exp_a;

    exp_o      = swap ? exp_b : exp_a;
    exp_s      = swap ? exp_a : exp_b;
    mant_big_o = swap ? mant_b : mant_a;
    mant_s     = swap ? mant_a : mant_b;
    shamt      = exp_o - exp_s;

    // Truncating shift; everything shifted out is simply lost.
    mant_small_o = (shamt >= 8'd24) ? 24'd0 : (mant_s >> shamt);
  end

endmodule

// File: rtl/sumsq_accum_fsm.sv
// Accumulates N_SAMPLES fp32 squares from the upstream squarer with a multi-cycle
// align/add/normalise FSM and emits the window sum with a one-cycle r_o pulse.
module sumsq_accum_fsm
  import fp32_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic        err_i,
  input  logic        r_i,
  output logic [31:0] sum,
  output logic        err,
  output logic        r_o,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(N_SAMPLES + 1);

  state_e          state_q;
  logic [31:0]     acc_q, b_q, sum_q;
  logic [CntW-1:0] cnt_q;
  logic            err_acc_q, err_q, r_o_q, busy_q;
  logic [7:0]      exp_q;
  logic [23:0]     mant_a_q, mant_b_q;
  logic [24:0]     m25_q;

  logic [7:0]      al_exp;
  logic [23:0]     al_big, al_small;

  fp32_align u_align (
    .a_i          (acc_q[30:0]),
    .b_i          (b_q[30:0]),
    .exp_o        (al_exp),
    .mant_big_o   (al_big),
    .mant_small_o (al_small)
  );

  logic [8:0]      norm_exp;
  logic [22:0]     norm_frac;
  logic            norm_ovf, inf_in;
  logic [31:0]     norm_acc;
  logic [CntW-1:0] cnt_inc;

  always_comb begin
    if (m25_q[24]) begin
      norm_frac = m25_q[23:1];
      norm_exp  = {1'b0, exp_q} + 9'd1;
    end else begin
      norm_frac = m25_q[22:0];
      norm_exp  = {1'b0, exp_q};
    end
    // An infinite accumulator stays infinite for the rest of the window.
    inf_in   = is_inf_nan(acc_q) || is_inf_nan(b_q);
    norm_ovf = norm_exp >= {1'b0, FP_EXP_MAX};
    norm_acc = (inf_in || norm_ovf) ? FP_POS_INF : {1'b0, norm_exp[7:0], norm_frac};
    cnt_inc  = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= FP_ZERO;
      b_q       <= FP_ZERO;
      cnt_q     <= '0;
      err_acc_q <= 1'b0;
      exp_q     <= 8'd0;
      mant_a_q  <= 24'd0;
      mant_b_q  <= 24'd0;
      m25_q     <= 25'd0;
      sum_q     <= FP_ZERO;
      err_q     <= 1'b0;
      r_o_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      r_o_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (r_i) begin
            // Negative squares are flagged but added by magnitude.
            b_q       <= {1'b0, x[30:0]};
            err_acc_q <= err_acc_q | err_i | x[31] | is_inf_nan(x);
            state_q   <= ST_ALIGN;
            busy_q    <= 1'b1;
          end
        end
        ST_ALIGN: begin
          exp_q    <= al_exp;
          mant_a_q <= al_big;
          mant_b_q <= al_small;
          state_q  <= ST_ADD;
        end
        ST_ADD: begin
          m25_q   <= {1'b0, mant_a_q} + {1'b0, mant_b_q};
          state_q <= ST_NORM;
        end
        ST_NORM: begin
          acc_q     <= norm_acc;
          err_acc_q <= err_acc_q | norm_ovf;
          cnt_q     <= cnt_inc;
          if (cnt_inc == CntW'(N_SAMPLES)) begin
            state_q <= ST_EMIT;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_EMIT: begin
          sum_q     <= acc_q;
          err_q     <= err_acc_q;
          r_o_q     <= 1'b1;
          acc_q     <= FP_ZERO;
          cnt_q     <= '0;
          err_acc_q <= 1'b0;
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sum  = sum_q;
  assign err  = err_q;
  assign r_o  = r_o_q;
  assign busy = busy_q;

endmodule
